denoise_multi: RTL and testbench
================================

Name: denoise_multi

Overview:
- Parametrised successor of the strip-based 3x3 denoise filter.
- Accepts a strip-scanned pixel stream with channel-interleaved samples, one sample per valid beat.
- Holds the two previous columns per channel.
- Emits one 3x3-filtered sample per interior pixel and channel, using a per-strip mode: bypass, box mean or binomial 1-2-1.
- Sits between demosaic and the colour/gamma stages of the ISP pipeline; no backpressure.

Parameters:
- COLOR_DEPTH, 8: bits per sample.
- STRIP_ROWS, 6: rows per strip column (>=3); outputs cover rows 1..STRIP_ROWS-2.
- NUM_CH, 3: channels interleaved per pixel (1..8), index 0..NUM_CH-1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pixel_in  in  COLOR_DEPTH  input sample.
- valid_in  in  1  sample valid; gaps allowed anywhere.
- mode_in  in  2  0 bypass, 1 box mean, 2 binomial, 3 treated as bypass.
- last_col_in  in  1  marks final beat of a strip's last column.
- last_pic_in  in  1  marks final beat of the picture.
- pixel_out  out  COLOR_DEPTH  filtered sample.
- valid_out  out  1  output beat valid.
- color_out  out  3  channel index of pixel_out; 3'd7 when idle.
- last_col_out  out  1  final output beat of the strip.
- last_pic_out  out  1  final output beat of the picture.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs are 0, except color_out=7.
  - Row, channel and column counters are 0; the mode register is 0.
  - Column buffers are not cleared and are never read before being rewritten.
- Scan order within a strip:
  - Column-major: column c, rows 0..STRIP_ROWS-1, each row NUM_CH beats for channels 0..NUM_CH-1.
  - Counters advance only on valid_in=1. Channel wraps to row++, row wraps to col++.
- Column counter:
  - Saturates at 2.
  - On the final beat of a column with last_col_in=1, it returns to 0 and a new strip starts.
- last_col_in / last_pic_in:
  - Sampled only on the final beat of a column (row=STRIP_ROWS-1, ch=NUM_CH-1); ignored elsewhere.
  - last_pic_in=1 also ends the strip.
- Mode:
  - mode_in is latched on the first beat of each strip (col=0, row=0, ch=0).
  - That value is held for the whole strip; mid-strip changes have no effect.
- Output trigger:
  - An input beat at (row r, col c, ch k) with r>=2 and col count=2 produces exactly one output.
  - The output is the centre (r-1, c-1, ch k) over window rows r-2..r, columns c-2..c, channel k.
  - Outputs per column = (STRIP_ROWS-2)*NUM_CH. Columns 0 and 1 of each strip produce none.
- Latency: an input beat sampled at edge k gives valid_out=1 after edge k+4. Fixed, independent of gaps.
- Ordering: output order equals trigger order; color_out=k.
- Arithmetic (no overflow):
  - Sum width is COLOR_DEPTH+4.
  - Bypass: centre sample.
  - Box: (S9+4)/9, where S9 is the sum of the nine samples; max 255 maps to 255.
  - Binomial: (Sw+8)>>4, with weights corners 1, edges 2, centre 4.
- Flags:
  - last_col_out=1 only on the output beat triggered by the strip-ending input beat.
  - last_pic_out=1 likewise for the picture-ending beat, together with last_col_out.
  - If the strip had fewer than 3 columns, no output and no flags are produced.
- Idle cycles: valid_out=0, color_out=7, flags 0; pixel_out holds its last value.
- Reset mid-strip:
  - In-flight pipeline beats are discarded; valid_out=0 from the cycle after the reset edge.
  - The next valid beat is treated as col 0, row 0, ch 0.

Test Plan:
1. Constant field: all samples 100, mode 1, 3 columns, NUM_CH=3, STRIP_ROWS=6.
   -> 12 outputs, all 100.
   -> color_out sequence 0,1,2 repeated.
   -> last_col_out only on the 12th output.
2. Impulse: 255 at (row2, col1, ch0), all else 0.
   -> Mode 1: output (2,1,0)=28, all other ch0 outputs 28 where the window covers the impulse.
   -> Mode 2: centre 64, edge-adjacent 32, diagonal 16.
3. Bypass: mode 0, ramp data.
   -> Each output equals the sample at (r-1, c-1, k).
   -> valid_out exactly 4 edges after each triggering input beat.
4. Gaps: test 2 stimulus with valid_in low every other cycle.
   -> Identical output values and order; each output 4 edges after its trigger.
5. Multi-strip: strip A of 4 columns in mode 2, mode_in toggled to 1 mid-strip, then strip B of 3 columns in mode 1 with last_pic_in.
   -> Strip A is filtered entirely in mode 2.
   -> Strip B columns 0..1 produce no outputs.
   -> last_pic_out and last_col_out are both set on the final output only.
6. Reset: rst high for 1 cycle mid-column 2.
   -> valid_out=0 from the next cycle, color_out=7.
   -> A subsequent fresh strip produces its first output on row 2 of column 2.

Source files
------------

// File: rtl/denoise_multi.sv
// Strip-scanned, channel-interleaved 3x3 denoise filter (bypass / box mean / binomial).
// Keeps two previous columns plus the current one per channel; five-register result path.
module denoise_multi #(
    parameter int COLOR_DEPTH = 8,
    parameter int STRIP_ROWS  = 6,
    parameter int NUM_CH      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COLOR_DEPTH-1:0] pixel_in,
    input  logic                   valid_in,
    input  logic [1:0]             mode_in,
    input  logic                   last_col_in,
    input  logic                   last_pic_in,
    output logic [COLOR_DEPTH-1:0] pixel_out,
    output logic                   valid_out,
    output logic [2:0]             color_out,
    output logic                   last_col_out,
    output logic                   last_pic_out
);
    localparam int W     = COLOR_DEPTH;
    localparam int COL_W = W + 2;
    localparam int SUM_W = W + 4;
    localparam int ROW_W = $clog2(STRIP_ROWS);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    function automatic logic [W-1:0] box_round(input logic [SUM_W-1:0] s);
        return W'((s + SUM_W'(4)) / SUM_W'(9));
    endfunction

    function automatic logic [W-1:0] binom_round(input logic [SUM_W-1:0] s);
        return W'((s + SUM_W'(8)) >> 4);
    endfunction

    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       mode_q, mode_d;
    logic             last_ch, last_row, col_end, strip_end, first_beat, trigger;
    logic [ROW_W-1:0] rsel [3];

    always_comb begin
        last_ch    = (ch_q == CH_W'(NUM_CH - 1));
        last_row   = (row_q == ROW_W'(STRIP_ROWS - 1));
        col_end    = valid_in && last_ch && last_row;
        strip_end  = col_end && (last_col_in || last_pic_in);
        first_beat = valid_in && (col_q == 2'd0) && (row_q == '0) && (ch_q == '0);
        trigger    = valid_in && (col_q == 2'd2) && (row_q >= ROW_W'(2));
        rsel[0]    = row_q - ROW_W'(2);
        rsel[1]    = row_q - ROW_W'(1);
        rsel[2]    = row_q;
        row_d      = row_q;
        ch_d       = ch_q;
        col_d      = col_q;
        mode_d     = mode_q;
        if (first_beat) mode_d = mode_in;
        if (valid_in) begin
            if (last_ch) begin
                ch_d = '0;
                if (last_row) begin
                    row_d = '0;
                    // Column count saturates at 2: from then on every column completes a window.
                    if (strip_end)          col_d = 2'd0;
                    else if (col_q != 2'd2) col_d = col_q + 2'd1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    logic [W-1:0] cur_q [NUM_CH][STRIP_ROWS];
    logic [W-1:0] m1_q  [NUM_CH][STRIP_ROWS];
    logic [W-1:0] m2_q  [NUM_CH][STRIP_ROWS];

    always_ff @(posedge clk) begin
        if (valid_in) begin
            cur_q[ch_q][row_q] <= pixel_in;
            if (col_end) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    for (int r = 0; r < STRIP_ROWS; r++) begin
                        m2_q[k][r] <= m1_q[k][r];
                        m1_q[k][r] <= cur_q[k][r];
                    end
                end
                m1_q[NUM_CH-1][STRIP_ROWS-1] <= pixel_in;
            end
        end
    end

    logic [W-1:0]     win_p1 [3][3];
    logic [COL_W-1:0] csum_p2 [3];
    logic [COL_W-1:0] cw_p2 [3];
    logic [SUM_W-1:0] s9_p3, sw_p3;
    logic [W-1:0]     ctr_p2, ctr_p3, res_p4;
    logic [CH_W-1:0]  ch_p1, ch_p2, ch_p3, ch_p4;
    logic [1:0]       mode_p1, mode_p2, mode_p3;
    logic             lc_p1, lc_p2, lc_p3, lc_p4;
    logic             lp_p1, lp_p2, lp_p3, lp_p4;
    logic             vld_p1, vld_p2, vld_p3, vld_p4;

    always_ff @(posedge clk) begin
        // stage 1: window columns c-2, c-1, c; rows r-2..r
        if (trigger) begin
            for (int i = 0; i < 3; i++) begin
                win_p1[0][i] <= m2_q[ch_q][rsel[i]];
                win_p1[1][i] <= m1_q[ch_q][rsel[i]];
            end
            win_p1[2][0] <= cur_q[ch_q][rsel[0]];
            win_p1[2][1] <= cur_q[ch_q][rsel[1]];
            win_p1[2][2] <= pixel_in;
            ch_p1        <= ch_q;
            mode_p1      <= mode_q;
            lc_p1        <= strip_end;
            lp_p1        <= col_end && last_pic_in;
        end
        // stage 2: per-column plain and 1-2-1 weighted sums
        for (int j = 0; j < 3; j++) begin
            csum_p2[j] <= COL_W'(win_p1[j][0]) + COL_W'(win_p1[j][1]) + COL_W'(win_p1[j][2]);
            cw_p2[j]   <= COL_W'(win_p1[j][0]) + (COL_W'(win_p1[j][1]) << 1) + COL_W'(win_p1[j][2]);
        end
        ctr_p2  <= win_p1[1][1];
        ch_p2   <= ch_p1;
        mode_p2 <= mode_p1;
        lc_p2   <= lc_p1;
        lp_p2   <= lp_p1;
        // stage 3: full 3x3 sums
        s9_p3   <= SUM_W'(csum_p2[0]) + SUM_W'(csum_p2[1]) + SUM_W'(csum_p2[2]);
        sw_p3   <= SUM_W'(cw_p2[0]) + (SUM_W'(cw_p2[1]) << 1) + SUM_W'(cw_p2[2]);
        ctr_p3  <= ctr_p2;
        ch_p3   <= ch_p2;
        mode_p3 <= mode_p2;
        lc_p3   <= lc_p2;
        lp_p3   <= lp_p2;
        // stage 4: rounding and mode select
        case (mode_p3)
            2'd1:    res_p4 <= box_round(s9_p3);
            2'd2:    res_p4 <= binom_round(sw_p3);
            default: res_p4 <= ctr_p3;
        endcase
        ch_p4 <= ch_p3;
        lc_p4 <= lc_p3;
        lp_p4 <= lp_p3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            ch_q         <= '0;
            col_q        <= 2'd0;
            mode_q       <= 2'd0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            vld_p3       <= 1'b0;
            vld_p4       <= 1'b0;
            pixel_out    <= '0;
            valid_out    <= 1'b0;
            color_out    <= 3'd7;
            last_col_out <= 1'b0;
            last_pic_out <= 1'b0;
        end else begin
            row_q     <= row_d;
            ch_q      <= ch_d;
            col_q     <= col_d;
            mode_q    <= mode_d;
            vld_p1    <= trigger;
            vld_p2    <= vld_p1;
            vld_p3    <= vld_p2;
            vld_p4    <= vld_p3;
            valid_out <= vld_p4;
            if (vld_p4) begin
                pixel_out    <= res_p4;
                color_out    <= 3'(ch_p4);
                last_col_out <= lc_p4;
                last_pic_out <= lp_p4;
            end else begin
                color_out    <= 3'd7;
                last_col_out <= 1'b0;
                last_pic_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_denoise_multi.sv
// Directed + randomized bench for denoise_multi against a whole-strip image model.
module tb_denoise_multi;
    localparam int W    = 8;
    localparam int R    = 6;
    localparam int N    = 3;
    localparam int MAXC = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pixel_in;
    logic         valid_in;
    logic [1:0]   mode_in;
    logic         last_col_in;
    logic         last_pic_in;
    logic [W-1:0] pixel_out;
    logic         valid_out;
    logic [2:0]   color_out;
    logic         last_col_out;
    logic         last_pic_out;

    always #5 clk = ~clk;

    denoise_multi #(.COLOR_DEPTH(W), .STRIP_ROWS(R), .NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .mode_in(mode_in),
        .last_col_in(last_col_in), .last_pic_in(last_pic_in), .pixel_out(pixel_out),
        .valid_out(valid_out), .color_out(color_out), .last_col_out(last_col_out),
        .last_pic_out(last_pic_out)
    );

    typedef struct { int due; int pix; int ch; int lc; int lp; } exp_t;
    exp_t q[$];
    int img [MAXC][R][N];
    int cyc = 0, n_assert = 0, n_fail = 0, last_pix = 0, n_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out === 1'b1) n_out++;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("valid_out", valid_out, 1);
            chk("pixel_out", pixel_out, e.pix);
            chk("color_out", color_out, e.ch);
            chk("last_col_out", last_col_out, e.lc);
            chk("last_pic_out", last_pic_out, e.lp);
            last_pix = e.pix;
        end else begin
            chk("idle_valid", valid_out, 0);
            chk("idle_color", color_out, 7);
            chk("idle_last_col", last_col_out, 0);
            chk("idle_last_pic", last_pic_out, 0);
            chk("idle_pixel_hold", pixel_out, last_pix);
        end
    endtask

    task automatic drive(input int v, input int pix, input int md, input int lc, input int lp);
        valid_in    = v[0];
        pixel_in    = pix[W-1:0];
        mode_in     = md[1:0];
        last_col_in = lc[0];
        last_pic_in = lp[0];
    endtask

    function automatic int gen(int pat, int c, int r, int k);
        case (pat)
            0:       return 100;
            1:       return (c == 1 && r == 2 && k == 0) ? 255 : 0;
            2:       return (c * 37 + r * 11 + k * 5) % 256;
            4:       return ($urandom_range(0, 3) != 0) ? 255 : 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Expected output for centre (r-1, c-1) of channel k, from the stored strip image.
    function automatic int model(int md, int c, int r, int k);
        int s9 = 0;
        int sw = 0;
        for (int dc = -1; dc <= 1; dc++) begin
            for (int dr = -1; dr <= 1; dr++) begin
                int v;
                v  = img[c-1+dc][r-1+dr][k];
                s9 += v;
                sw += v * ((dc == 0) ? 2 : 1) * ((dr == 0) ? 2 : 1);
            end
        end
        case (md)
            1:       return (s9 + 4) / 9;
            2:       return (sw + 8) / 16;
            default: return img[c-1][r-1][k];
        endcase
    endfunction

    task automatic send_strip(input int ncols, input int md, input int pat, input int lastpic,
                              input int gaps, input int abort_at);
        int b = 0;
        for (int c = 0; c < ncols; c++) begin
            for (int r = 0; r < R; r++) begin
                for (int k = 0; k < N; k++) begin
                    int pix, mdin, lc, lp;
                    bit colend, stripend;
                    if (b == abort_at) begin
                        rst = 1'b1;
                        drive(0, 0, 0, 0, 0);
                        q.delete();
                        last_pix = 0;
                        tick();
                        rst = 1'b0;
                        return;
                    end
                    b++;
                    pix = gen(pat, c, r, k);
                    img[c][r][k] = pix;
                    colend   = (r == R - 1) && (k == N - 1);
                    stripend = colend && (c == ncols - 1);
                    mdin = (c == 0 && r == 0 && k == 0) ? md : int'($urandom_range(0, 3));
                    if (colend) begin
                        lc = stripend ? (lastpic != 0 ? int'($urandom_range(0, 1)) : 1) : 0;
                        lp = (stripend && lastpic != 0) ? 1 : 0;
                    end else begin
                        lc = int'($urandom_range(0, 1));
                        lp = int'($urandom_range(0, 1));
                    end
                    drive(1, pix, mdin, lc, lp);
                    if (c >= 2 && r >= 2) begin
                        exp_t e;
                        e.due = cyc + 5;
                        e.pix = model(md, c, r, k);
                        e.ch  = k;
                        e.lc  = stripend ? 1 : 0;
                        e.lp  = (stripend && lastpic != 0) ? 1 : 0;
                        q.push_back(e);
                    end
                    tick();
                    if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
                        drive(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
                        tick();
                    end
                end
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        idle(2);

        n0 = n_out;
        send_strip(3, 1, 0, 0, 0, -1);
        idle(6);
        chk("t1_output_count", n_out - n0, 12);

        send_strip(3, 1, 1, 0, 0, -1);
        send_strip(3, 2, 1, 0, 0, -1);
        send_strip(4, 0, 2, 0, 0, -1);
        idle(6);

        send_strip(3, 1, 1, 0, 1, -1);
        send_strip(3, 2, 1, 0, 1, -1);
        idle(6);

        send_strip(4, 2, 3, 0, 0, -1);
        send_strip(3, 1, 3, 1, 0, -1);
        idle(6);

        n0 = n_out;
        send_strip(2, 1, 3, 0, 0, -1);
        send_strip(1, 2, 3, 1, 0, -1);
        idle(6);
        chk("short_strip_outputs", n_out - n0, 0);

        send_strip(3, 2, 3, 0, 0, 2 * R * N + 3 * N + 1);
        chk("reset_valid", valid_out, 0);
        chk("reset_color", color_out, 7);
        send_strip(3, 1, 4, 0, 2, -1);
        idle(6);

        for (int i = 0; i < 10; i++) begin
            send_strip(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                       int'($urandom_range(3, 4)), (i == 9) ? 1 : int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)), -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 6)));
        end
        idle(8);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
